// File: rtl/wb_gpio_pkg.sv
// Register map constants and address decode helpers for the Wishbone GPIO block.
// Latency: none, constants and pure functions only.
// Backpressure: not applicable.
package wb_gpio_pkg;

  localparam logic [4:0] LED_OFF  = 5'h00;
  localparam logic [4:0] SET_OFF  = 5'h04;
  localparam logic [4:0] CLR_OFF  = 5'h08;
  localparam logic [4:0] TGL_OFF  = 5'h0C;
  localparam logic [4:0] BTN_OFF  = 5'h10;
  localparam logic [4:0] STAT_OFF = 5'h14;
  localparam logic [4:0] MASK_OFF = 5'h18;
  localparam logic [4:0] EDGE_OFF = 5'h1C;

  localparam int unsigned REG_WINDOW = 32;

  // Unsigned distance from the base makes addresses below the base wrap to a
  // huge value, so a single compare covers both ends of the window.
  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
    logic [31:0] rel;
    rel = addr - base;
    return (rel < REG_WINDOW) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/wb_gpio_irq_if.sv
// Wishbone classic-pipelined slave port bundle for the GPIO block.
// Latency: none, wiring only.
// Backpressure: stall is carried but the slave always drives it low.
interface wb_gpio_irq_if;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        i_wb_we;
  logic [3:0]  i_wb_sel;
  logic [31:0] i_wb_addr;
  logic [31:0] i_wb_data;
  logic        o_wb_ack;
  logic        o_wb_stall;
  logic [31:0] o_wb_data;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_sel, i_wb_addr, i_wb_data,
    input  o_wb_ack, o_wb_stall, o_wb_data
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_sel, i_wb_addr, i_wb_data,
    output o_wb_ack, o_wb_stall, o_wb_data
  );
endinterface

// File: rtl/wb_gpio_irq_debounce.sv
// One button bit: 2-FF synchroniser followed by a stable-count debouncer.
// Latency: DEBOUNCE_CYCLES+2 edges from raw change to deb (3 when bypassed).
// Backpressure: none, free-running per clock.
module gpio_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic deb
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0] sync_q;
  logic       sync;

  assign sync = sync_q[1];

  // Bring the asynchronous input into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], raw};
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      // No filtering: follow the synchronised value directly.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) deb <= 1'b0;
        else          deb <= sync;
      end
    end else begin : g_count
      logic [CW-1:0] cnt;

      // Count consecutive cycles of disagreement; any agreement restarts it.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt <= '0;
          deb <= 1'b0;
        end else if (sync == deb) begin
          cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt <= '0;
          deb <= sync;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/wb_gpio_irq.sv
// Wishbone GPIO: LED register with set/clr/toggle aliases, debounced buttons, edge IRQs.
// Latency: ack and read data one cycle after each request; writes land on the request edge.
// Backpressure: never stalls; out-of-window or misaligned requests are simply not acked.
module wb_gpio_irq
  import wb_gpio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS    = 32'h3000_0000,
  parameter int          N_LEDS          = 8,
  parameter int          N_BUTTONS       = 3,
  parameter int          DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  wb_gpio_irq_if.slave         wb,
  input  logic [N_BUTTONS-1:0] buttons,
  output logic [N_LEDS-1:0]    leds,
  output logic                 irq
);

  // Edge-enable halves of EDGE_CFG are 16 bits wide, so N_BUTTONS must not exceed 16.

  logic                 req;
  logic                 wr;
  logic [4:0]           off;
  logic [31:0]          wdat;
  logic [3:0]           sel;
  logic [31:0]          rd_mux;

  logic [N_LEDS-1:0]    led_q;
  logic [N_BUTTONS-1:0] deb;
  logic [N_BUTTONS-1:0] deb_q;
  logic [N_BUTTONS-1:0] stat_q;
  logic [N_BUTTONS-1:0] mask_q;
  logic [N_BUTTONS-1:0] rise_en_q;
  logic [N_BUTTONS-1:0] fall_en_q;
  logic [N_BUTTONS-1:0] ev;
  logic [N_BUTTONS-1:0] stat_clr;
  logic                 ack_q;
  logic [31:0]          rdata_q;
  logic                 irq_q;
  logic                 unused_wb;

  assign req  = wb.i_wb_cyc & wb.i_wb_stb & in_window(wb.i_wb_addr, BASE_ADDRESS);
  assign wr   = req & wb.i_wb_we;
  assign off  = wb.i_wb_addr[4:0] - BASE_ADDRESS[4:0];
  assign wdat = wb.i_wb_data;
  assign sel  = wb.i_wb_sel;

  // Upper data bits and some select bits have no home for small parameter values.
  assign unused_wb = &{1'b0, wdat, sel};

  assign wb.o_wb_ack   = ack_q;
  assign wb.o_wb_data  = rdata_q;
  assign wb.o_wb_stall = 1'b0;
  assign leds          = led_q;
  assign irq           = irq_q;

  genvar gi;
  generate
    for (gi = 0; gi < N_BUTTONS; gi++) begin : g_btn
      gpio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (buttons[gi]),
        .deb     (deb[gi])
      );
    end
  endgenerate

  assign ev       = (deb & ~deb_q & rise_en_q) | (~deb & deb_q & fall_en_q);
  assign stat_clr = (wr && off == STAT_OFF) ? wdat[N_BUTTONS-1:0] : '0;

  // Read mux; write-only aliases and unused bits read as zero.
  always_comb begin
    rd_mux = 32'h0;
    case (off)
      LED_OFF:  rd_mux = 32'(led_q);
      BTN_OFF:  rd_mux = 32'(deb);
      STAT_OFF: rd_mux = 32'(stat_q);
      MASK_OFF: rd_mux = 32'(mask_q);
      EDGE_OFF: rd_mux = {16'(fall_en_q), 16'(rise_en_q)};
      default:  rd_mux = 32'h0;
    endcase
  end

  // Bus response: one ack per accepted strobe, data captured alongside it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      ack_q <= req;
      if (req) rdata_q <= rd_mux;
    end
  end

  // LED register: byte-selected direct write, full-word set/clear/toggle aliases.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_q <= '0;
    end else if (wr) begin
      case (off)
        LED_OFF: begin
          for (int i = 0; i < N_LEDS; i++)
            if (sel[i/8]) led_q[i] <= wdat[i];
        end
        SET_OFF: led_q <= led_q | wdat[N_LEDS-1:0];
        CLR_OFF: led_q <= led_q & ~wdat[N_LEDS-1:0];
        TGL_OFF: led_q <= led_q ^ wdat[N_LEDS-1:0];
        default: ;
      endcase
    end
  end

  // Interrupt mask and edge enables, byte-selected writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q    <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
    end else if (wr) begin
      if (off == MASK_OFF) begin
        for (int i = 0; i < N_BUTTONS; i++)
          if (sel[i/8]) mask_q[i] <= wdat[i];
      end
      if (off == EDGE_OFF) begin
        for (int i = 0; i < N_BUTTONS; i++) begin
          if (sel[i/8])        rise_en_q[i] <= wdat[i];
          if (sel[(16+i)/8])   fall_en_q[i] <= wdat[16+i];
        end
      end
    end
  end

  // Edge history and sticky status; a new event beats a same-cycle W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_q  <= '0;
      stat_q <= '0;
    end else begin
      deb_q  <= deb;
      stat_q <= (stat_q & ~stat_clr) | ev;
    end
  end

  // Registered level interrupt from enabled status bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= |(stat_q & mask_q);
  end

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Scoreboard bench for wb_gpio_irq: stimulus queues expected acks, a monitor checks them.
// Latency: expects ack and read data exactly one cycle after each request.
// Backpressure: stall is never asserted, so strobes are issued back-to-back freely.
module tb_wb_gpio_irq;
  import wb_gpio_pkg::*;

  localparam logic [31:0] BASE = 32'h3000_0000;

  typedef struct {
    int unsigned cyc;
    bit          chk;
    logic [31:0] data;
    string       name;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic [2:0] buttons;
  logic [7:0] leds;
  logic       irq;

  int unsigned cyc_cnt;
  int          checks;
  int          failures;
  exp_t        sb[$];
  exp_t        mon_e;

  wb_gpio_irq_if wb();

  wb_gpio_irq #(
    .BASE_ADDRESS    (BASE),
    .N_LEDS          (8),
    .N_BUTTONS       (3),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wb      (wb),
    .buttons (buttons),
    .leds    (leds),
    .irq     (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every ack must match the oldest queued expectation in cycle and data.
  always @(negedge clk) begin
    if (wb.o_wb_ack === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack: ack at cycle %0d, expected none", cyc_cnt);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_ack_cycle"}, cyc_cnt, mon_e.cyc);
        if (mon_e.chk) check({mon_e.name, "_data"}, wb.o_wb_data, mon_e.data);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one strobe cycle; optionally queue the expected ack and leave strobe up.
  task automatic bus(input bit we, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] sel, input bit push, input bit chk,
                     input logic [31:0] exp, input string name, input bit keep);
    exp_t e;
    wb.i_wb_cyc  = 1'b1;
    wb.i_wb_stb  = 1'b1;
    wb.i_wb_we   = we;
    wb.i_wb_addr = addr;
    wb.i_wb_data = data;
    wb.i_wb_sel  = sel;
    if (push) begin
      e.cyc  = cyc_cnt + 1;
      e.chk  = chk;
      e.data = exp;
      e.name = name;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!keep) begin
      wb.i_wb_cyc = 1'b0;
      wb.i_wb_stb = 1'b0;
      wb.i_wb_we  = 1'b0;
    end
  endtask

  task automatic wr(input logic [4:0] o, input logic [31:0] d, input logic [3:0] s, input string name);
    bus(1'b1, BASE + 32'(o), d, s, 1'b1, 1'b0, 32'h0, name, 1'b0);
  endtask

  task automatic rd(input logic [4:0] o, input logic [31:0] exp, input string name);
    bus(1'b0, BASE + 32'(o), 32'h0, 4'hF, 1'b1, 1'b1, exp, name, 1'b0);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    cyc_cnt     = 0;
    reset_n     = 1'b0;
    buttons     = 3'b000;
    wb.i_wb_cyc  = 1'b0;
    wb.i_wb_stb  = 1'b0;
    wb.i_wb_we   = 1'b0;
    wb.i_wb_sel  = 4'h0;
    wb.i_wb_addr = 32'h0;
    wb.i_wb_data = 32'h0;
    wait_cyc(3);
    check("rst_leds", 32'(leds), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_ack", 32'(wb.o_wb_ack), 32'h0);
    check("rst_data", wb.o_wb_data, 32'h0);
    reset_n = 1'b1;
    wait_cyc(2);

    // Reset-state reads and byte-select on LED writes.
    rd(LED_OFF, 32'h0, "rd_led_rst");
    rd(BTN_OFF, 32'h0, "rd_btn_rst");
    rd(STAT_OFF, 32'h0, "rd_stat_rst");
    wr(LED_OFF, 32'h0000_00A5, 4'b0001, "wr_led_a5");
    check("leds_a5", 32'(leds), 32'hA5);
    wr(LED_OFF, 32'h0000_00FF, 4'b0000, "wr_led_nosel");
    check("leds_nosel", 32'(leds), 32'hA5);

    // Aliases ignore sel and act on the whole word.
    wr(SET_OFF, 32'h0000_000A, 4'b0000, "wr_set");
    check("leds_set", 32'(leds), 32'hAF);
    wr(CLR_OFF, 32'h0000_0081, 4'b0000, "wr_clr");
    check("leds_clr", 32'(leds), 32'h2E);
    wr(TGL_OFF, 32'h0000_00FF, 4'b0000, "wr_tgl");
    check("leds_tgl", 32'(leds), 32'hD1);
    rd(LED_OFF, 32'h0000_00D1, "rd_led_d1");
    rd(SET_OFF, 32'h0, "rd_set_wo");
    bus(1'b0, BASE + 32'h1, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, "rd_misaligned", 1'b0);

    // Debounce latency: deb changes on the 6th edge after the raw change.
    buttons = 3'b010;
    wait_cyc(5);
    rd(BTN_OFF, 32'h0, "btn_edge6_old");
    rd(BTN_OFF, 32'h2, "btn_edge7_new");
    // A 3-cycle glitch on bit0 must never reach BTN.
    buttons = 3'b011;
    wait_cyc(3);
    buttons = 3'b010;
    for (int i = 0; i < 12; i++) rd(BTN_OFF, 32'h2, "btn_glitch");

    // Edge detection, sticky status, mask and irq.
    wr(EDGE_OFF, 32'h0001_0002, 4'hF, "wr_edge");
    wr(MASK_OFF, 32'h0000_0003, 4'hF, "wr_mask");
    rd(EDGE_OFF, 32'h0001_0002, "rd_edge");
    buttons = 3'b000;
    wait_cyc(10);
    rd(STAT_OFF, 32'h0, "stat_fall1_off");
    buttons = 3'b010;
    wait_cyc(10);
    rd(STAT_OFF, 32'h2, "stat_rise1");
    check("irq_rise1", 32'(irq), 32'h1);
    buttons = 3'b011;
    wait_cyc(10);
    buttons = 3'b010;
    wait_cyc(10);
    rd(STAT_OFF, 32'h3, "stat_fall0");
    wr(STAT_OFF, 32'h0000_0003, 4'b0000, "wr_stat_clr");
    check("irq_hold_1cyc", 32'(irq), 32'h1);
    wait_cyc(1);
    check("irq_cleared", 32'(irq), 32'h0);
    rd(STAT_OFF, 32'h0, "stat_cleared");

    // W1C landing on the same edge as a new rise on bit1: the event wins.
    buttons = 3'b000;
    wait_cyc(10);
    buttons = 3'b010;
    wait_cyc(10);
    check("irq_pre_race", 32'(irq), 32'h1);
    buttons = 3'b000;
    wait_cyc(10);
    buttons = 3'b010;
    wait_cyc(6);
    wr(STAT_OFF, 32'h0000_0002, 4'b0000, "wr_stat_race");
    for (int i = 0; i < 3; i++) begin
      check("irq_race_hold", 32'(irq), 32'h1);
      wait_cyc(1);
    end
    rd(STAT_OFF, 32'h2, "stat_race");

    // Back-to-back strobes; the out-of-window one gets no ack.
    bus(1'b1, BASE + 32'(LED_OFF), 32'h0000_003C, 4'b0001, 1'b1, 1'b0, 32'h0, "burst_wr", 1'b1);
    bus(1'b0, BASE + 32'(LED_OFF), 32'h0, 4'hF, 1'b1, 1'b1, 32'h3C, "burst_rd_led", 1'b1);
    bus(1'b0, BASE + 32'(BTN_OFF), 32'h0, 4'hF, 1'b1, 1'b1, 32'h2, "burst_rd_btn", 1'b1);
    bus(1'b0, BASE + 32'h20, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, "burst_oow", 1'b0);
    check("leds_burst", 32'(leds), 32'h3C);
    wait_cyc(2);

    // Reset in the middle of a burst drops ack and clears state at once.
    bus(1'b1, BASE + 32'(LED_OFF), 32'h0000_0055, 4'b0001, 1'b0, 1'b0, 32'h0, "rst_burst_wr", 1'b1);
    wb.i_wb_we   = 1'b0;
    wb.i_wb_addr = BASE + 32'(BTN_OFF);
    check("ack_before_rst", 32'(wb.o_wb_ack), 32'h1);
    check("leds_before_rst", 32'(leds), 32'h55);
    #2;
    reset_n = 1'b0;
    #1;
    check("ack_async_rst", 32'(wb.o_wb_ack), 32'h0);
    check("leds_async_rst", 32'(leds), 32'h0);
    wait_cyc(2);
    wb.i_wb_cyc = 1'b0;
    wb.i_wb_stb = 1'b0;
    reset_n = 1'b1;
    wait_cyc(1);
    check("irq_after_rst", 32'(irq), 32'h0);
    rd(LED_OFF, 32'h0, "rd_led_after_rst");
    rd(STAT_OFF, 32'h0, "rd_stat_after_rst");

    wait_cyc(3);
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
